// File: rtl/ghr_unit_pkg.sv
// Shared types for the speculative global-history manager and its outstanding branch queue.
package ghr_unit_pkg;

    localparam int unsigned BH_SIZE  = 10;
    localparam int unsigned OBQ_SIZE = 16;
    localparam int unsigned TAG_W    = $clog2(OBQ_SIZE) + 1;

    typedef struct packed {
        logic [BH_SIZE-1:0] branch_history;
    } obq_row_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } ghr_state_t;

endpackage

// File: rtl/ghr_unit_if.sv
// Fetch / execute / OBQ-write-side signal bundle around ghr_unit.
interface ghr_unit_if;
    import ghr_unit_pkg::*;

    logic             br_valid;
    logic             br_taken;
    logic             br_ready;
    logic [TAG_W-1:0] br_tag;
    logic [BH_SIZE-1:0] ghr;
    logic             mispredict_en;
    logic [TAG_W-1:0] mispredict_tag;
    logic             retire_en;
    logic [TAG_W-1:0] obq_tail;
    logic             obq_bh_pred_valid;
    obq_row_t         obq_bh_pred;
    logic             obq_write_en;
    obq_row_t         obq_bh_row;
    logic             obq_clear_en;
    logic [TAG_W-1:0] obq_index;
    logic             obq_shift_en;
    logic [TAG_W-1:0] obq_shift_index;

    modport master (
        output br_valid, br_taken, mispredict_en, mispredict_tag, retire_en,
               obq_tail, obq_bh_pred_valid, obq_bh_pred,
        input  br_ready, br_tag, ghr, obq_write_en, obq_bh_row, obq_clear_en,
               obq_index, obq_shift_en, obq_shift_index
    );

    modport slave (
        input  br_valid, br_taken, mispredict_en, mispredict_tag, retire_en,
               obq_tail, obq_bh_pred_valid, obq_bh_pred,
        output br_ready, br_tag, ghr, obq_write_en, obq_bh_row, obq_clear_en,
               obq_index, obq_shift_en, obq_shift_index
    );

endinterface

// File: rtl/ghr_unit.sv
// Speculative GHR: shifts predictions in, pushes history rows to the OBQ,
// truncates the OBQ on mispredict and reloads the GHR from the corrected row.
module ghr_unit #(
    parameter int unsigned BH_SIZE  = ghr_unit_pkg::BH_SIZE,
    parameter int unsigned OBQ_SIZE = ghr_unit_pkg::OBQ_SIZE
) (
    input  logic       clock,
    input  logic       reset,
    ghr_unit_if.slave  bus
);
    import ghr_unit_pkg::*;

    localparam int unsigned TAG_W = $clog2(OBQ_SIZE) + 1;

    ghr_state_t         state_q, state_d;
    logic [BH_SIZE-1:0] ghr_q, ghr_d;
    logic [BH_SIZE-1:0] ghr_push;
    logic [TAG_W-1:0]   eff_tail;
    logic               mispredict_take;
    logic               br_ready_c;
    logic               write_c;

    // A same-cycle retire frees the head slot before the push lands.
    always_comb begin
        eff_tail        = bus.obq_tail - TAG_W'(bus.retire_en);
        mispredict_take = bus.mispredict_en && (state_q == NORMAL)
                          && (bus.mispredict_tag < bus.obq_tail);
        br_ready_c      = reset && (state_q == NORMAL) && !mispredict_take
                          && (eff_tail < TAG_W'(OBQ_SIZE));
        write_c         = bus.br_valid && br_ready_c;
        ghr_push        = {bus.br_taken, ghr_q[BH_SIZE-1:1]};
    end

    always_comb begin
        state_d = state_q;
        ghr_d   = ghr_q;
        case (state_q)
            NORMAL: begin
                if (mispredict_take) state_d = RECOVER;
                if (write_c)         ghr_d   = ghr_push;
            end
            RECOVER: begin
                // OBQ youngest row already carries the flipped direction.
                state_d = NORMAL;
                if (bus.obq_bh_pred_valid) ghr_d = bus.obq_bh_pred.branch_history;
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= NORMAL;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ghr_q   <= ghr_d;
        end
    end

    assign bus.br_ready                  = br_ready_c;
    assign bus.br_tag                    = eff_tail;
    assign bus.ghr                       = ghr_q;
    assign bus.obq_write_en              = write_c;
    assign bus.obq_bh_row.branch_history = ghr_push;
    assign bus.obq_clear_en              = reset && mispredict_take;
    assign bus.obq_index                 = (reset && mispredict_take)
                                           ? bus.mispredict_tag + TAG_W'(1) : '0;
    assign bus.obq_shift_en              = reset && bus.retire_en;
    assign bus.obq_shift_index           = '0;

    // Protocol guards: never retire from an empty OBQ, never clear to an empty OBQ then shift.
    assert property (@(posedge clock) disable iff (!reset)
        !(bus.retire_en && (bus.obq_tail == '0)));
    assert property (@(posedge clock) disable iff (!reset)
        !(bus.retire_en && mispredict_take && (bus.mispredict_tag == '0)));

endmodule
